// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader: word geometry, default widths
// and the loader state encoding.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        BYTES,
        WRITE,
        CSUM,
        DONE
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Bundle of the loader's byte-stream input, instruction-memory write port and
// CPU control outputs. The loader uses the slave view, the surrounding system
// (or a bench) uses the master view.
interface program_loader_if import cpu_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
    );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Collects bytes MSB-first into an instruction word. word_complete flags the
// cycle in which the last byte of a word is being shifted in, so the next
// cycle sees the finished word on the output.
module word_assembler import cpu_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_complete
);

    logic [1:0] byte_cnt;

    assign word_complete = shift_en && (byte_cnt == 2'(WORD_BYTES - 1));

    // Shift register and byte position; clear drops any partial word at load start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {word[DATA_W-9:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a program from a byte stream into instruction memory while holding the
// CPU in reset. Stream format: word count byte (0 = 256), then 4 bytes per word
// MSB-first, then one XOR checksum byte over everything before it.
module program_loader import cpu_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus
);

    loader_state_t     state;
    loader_state_t     state_next;
    logic              in_ready_c;
    logic              wr_en_c;
    logic              done_c;
    logic              accept;
    logic              word_complete;
    logic              last_word;
    logic [7:0]        n_words;
    logic [7:0]        csum;
    logic              err_q;
    logic [ADDR_W-1:0] word_idx;
    logic [DATA_W-1:0] word;

    assign accept    = bus.in_valid && in_ready_c;
    assign last_word = (word_idx == ADDR_W'(n_words - 8'd1));

    word_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk           (clk),
        .reset         (reset),
        .clear         (accept && (state == HDR)),
        .shift_en      (accept && (state == BYTES)),
        .byte_in       (bus.in_data),
        .word          (word),
        .word_complete (word_complete)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state strobes; every output is a pure function of state.
    always_comb begin
        state_next = state;
        in_ready_c = 1'b0;
        wr_en_c    = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = BYTES;
                end
            end
            BYTES: begin
                in_ready_c = 1'b1;
                if (word_complete) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr_en_c    = 1'b1;
                state_next = last_word ? CSUM : BYTES;
            end
            CSUM: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word count, word index, running checksum and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_words  <= '0;
            word_idx <= '0;
            csum     <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_q <= 1'b0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        n_words  <= bus.in_data;
                        word_idx <= '0;
                        csum     <= bus.in_data;
                    end
                end
                BYTES: begin
                    if (accept) begin
                        csum <= csum ^ bus.in_data;
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        word_idx <= word_idx + 1'b1;
                    end
                end
                CSUM: begin
                    if (accept && (bus.in_data != csum)) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.wr_en    = wr_en_c;
    assign bus.wr_addr  = word_idx;
    assign bus.wr_data  = word;
    assign bus.cpu_hold = (state != IDLE);
    assign bus.done     = done_c;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal load, checksum error, full 256-word
// load, reset mid-word, and a load with random gaps plus stray start pulses.
module tb_program_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] addr_q[$];
    logic [DATA_W-1:0] data_q[$];

    logic [7:0] std_bytes [8] = '{8'h38, 8'h01, 8'h00, 8'h05, 8'h38, 8'h02, 8'h00, 8'h01};

    program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    program_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [ADDR_W-1:0] qAddr(input int i);
        return (i < addr_q.size()) ? addr_q[i] : 'x;
    endfunction

    function automatic logic [DATA_W-1:0] qData(input int i);
        return (i < data_q.size()) ? data_q[i] : 'x;
    endfunction

    function automatic logic [31:0] t3Word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'hA5, b, ~b, b + 8'd1};
    endfunction

    // Capture every memory write and confirm the stream is stalled meanwhile.
    always @(negedge clk) begin
        if (bif.wr_en === 1'b1) begin
            addr_q.push_back(bif.wr_addr);
            data_q.push_back(bif.wr_data);
            checkOutput("in_ready_in_write", 64'(bif.in_ready), 64'd0);
        end
    end

    // Presents one byte after an optional idle gap and holds it until accepted.
    task automatic applyStimulus(input logic [7:0] b, input int gap, input bit poke_start);
        int waited;
        waited = 0;
        bif.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bif.start = poke_start && ($urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        bif.start    = 1'b0;
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        while (bif.in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) begin
            checkOutput("in_ready_timeout", 64'(bif.in_ready), 64'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        bif.in_valid = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
    endtask

    task automatic waitDone(input logic exp_err);
        int n;
        n = 0;
        @(negedge clk);
        while (bif.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_pulse", 64'(bif.done), 64'd1);
        checkOutput("err_at_done", 64'(bif.err), 64'(exp_err));
        checkOutput("hold_during_done", 64'(bif.cpu_hold), 64'd1);
        @(negedge clk);
        checkOutput("done_one_cycle", 64'(bif.done), 64'd0);
        checkOutput("hold_released", 64'(bif.cpu_hold), 64'd0);
        checkOutput("err_sticky", 64'(bif.err), 64'(exp_err));
    endtask

    task automatic loadStd(input logic [7:0] csum_byte, input int gapmax, input bit poke_start);
        applyStimulus(8'h02, $urandom_range(0, gapmax), poke_start);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(std_bytes[i], $urandom_range(0, gapmax), poke_start);
        end
        applyStimulus(csum_byte, $urandom_range(0, gapmax), poke_start);
    endtask

    initial begin
        logic [7:0] cs;
        logic [31:0] w;
        int bad;

        bif.start    = 1'b0;
        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;
        reset        = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_in_ready", 64'(bif.in_ready), 64'd0);
        checkOutput("rst_wr_en", 64'(bif.wr_en), 64'd0);
        checkOutput("rst_cpu_hold", 64'(bif.cpu_hold), 64'd0);
        checkOutput("rst_done", 64'(bif.done), 64'd0);
        checkOutput("rst_err", 64'(bif.err), 64'd0);
        checkOutput("rst_wr_addr", 64'(bif.wr_addr), 64'd0);
        checkOutput("rst_wr_data", 64'(bif.wr_data), 64'd0);
        reset = 1'b0;

        $display("[TB] two-word load, good checksum");
        addr_q.delete();
        data_q.delete();
        pulseStart();
        checkOutput("hdr_in_ready", 64'(bif.in_ready), 64'd1);
        checkOutput("hdr_cpu_hold", 64'(bif.cpu_hold), 64'd1);
        applyStimulus(8'h02, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(std_bytes[i], 0, 1'b0);
            if (i % 4 == 3) begin
                @(negedge clk);
                checkOutput("wr_en_latency", 64'(bif.wr_en), 64'd1);
            end
        end
        applyStimulus(8'h05, 0, 1'b0);
        waitDone(1'b0);
        checkOutput("t1_write_count", 64'(addr_q.size()), 64'd2);
        checkOutput("t1_addr0", 64'(qAddr(0)), 64'h00);
        checkOutput("t1_data0", 64'(qData(0)), 64'h38010005);
        checkOutput("t1_addr1", 64'(qAddr(1)), 64'h01);
        checkOutput("t1_data1", 64'(qData(1)), 64'h38020001);

        $display("[TB] two-word load, bad checksum");
        addr_q.delete();
        data_q.delete();
        pulseStart();
        loadStd(8'h00, 0, 1'b0);
        waitDone(1'b1);
        checkOutput("t2_write_count", 64'(addr_q.size()), 64'd2);
        checkOutput("t2_data1", 64'(qData(1)), 64'h38020001);
        repeat (5) @(negedge clk);
        checkOutput("t2_err_held", 64'(bif.err), 64'd1);

        $display("[TB] 256-word load");
        addr_q.delete();
        data_q.delete();
        pulseStart();
        checkOutput("t3_err_cleared", 64'(bif.err), 64'd0);
        cs = 8'h00;
        applyStimulus(8'h00, 0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            w = t3Word(i);
            for (int k = 3; k >= 0; k--) begin
                cs = cs ^ w[k*8 +: 8];
                applyStimulus(w[k*8 +: 8], 0, 1'b0);
            end
        end
        applyStimulus(cs, 0, 1'b0);
        waitDone(1'b0);
        checkOutput("t3_write_count", 64'(addr_q.size()), 64'd256);
        checkOutput("t3_last_addr", 64'(qAddr(255)), 64'hFF);
        checkOutput("t3_last_data", 64'(qData(255)), 64'(t3Word(255)));
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (qAddr(i) !== 8'(i) || qData(i) !== t3Word(i)) begin
                bad++;
            end
        end
        checkOutput("t3_bad_words", 64'(bad), 64'd0);

        $display("[TB] reset mid-word");
        addr_q.delete();
        data_q.delete();
        pulseStart();
        applyStimulus(8'h02, 0, 1'b0);
        applyStimulus(8'h38, 0, 1'b0);
        applyStimulus(8'h01, 0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t4_in_ready", 64'(bif.in_ready), 64'd0);
        checkOutput("t4_cpu_hold", 64'(bif.cpu_hold), 64'd0);
        checkOutput("t4_wr_en", 64'(bif.wr_en), 64'd0);
        checkOutput("t4_done", 64'(bif.done), 64'd0);
        checkOutput("t4_err", 64'(bif.err), 64'd0);
        checkOutput("t4_wr_addr", 64'(bif.wr_addr), 64'd0);
        checkOutput("t4_wr_data", 64'(bif.wr_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t4_no_write", 64'(addr_q.size()), 64'd0);
        pulseStart();
        loadStd(8'h05, 0, 1'b0);
        waitDone(1'b0);
        checkOutput("t4_write_count", 64'(addr_q.size()), 64'd2);
        checkOutput("t4_addr0", 64'(qAddr(0)), 64'h00);
        checkOutput("t4_data0", 64'(qData(0)), 64'h38010005);

        $display("[TB] gaps and stray starts");
        addr_q.delete();
        data_q.delete();
        pulseStart();
        loadStd(8'h05, 3, 1'b1);
        waitDone(1'b0);
        checkOutput("t5_write_count", 64'(addr_q.size()), 64'd2);
        checkOutput("t5_addr0", 64'(qAddr(0)), 64'h00);
        checkOutput("t5_data0", 64'(qData(0)), 64'h38010005);
        checkOutput("t5_addr1", 64'(qAddr(1)), 64'h01);
        checkOutput("t5_data1", 64'(qData(1)), 64'h38020001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the loader wedges somewhere the bounded waits miss.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address width (256 words).
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width; fixed at 4 bytes.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a program load.
REQ-006 SHALL have port in_valid  input  1  byte stream valid.
REQ-007 SHALL have port in_data  input  8  byte stream data.
REQ-008 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 SHALL have port wr_addr  output  ADDR_W  word address for write.
REQ-011 SHALL have port wr_data  output  DATA_W  word to write.
REQ-012 SHALL have port cpu_hold  output  1  holds CPU in reset while loading.
REQ-013 SHALL have port done  output  1  one-cycle pulse at load end.
REQ-014 SHALL have port err  output  1  checksum mismatch, sticky until next accepted start.

Function
REQ-015 SHALL transfer a byte only on a rising edge where in_valid and in_ready are both 1; in_data is not consumed otherwise.
REQ-016 SHALL implement states IDLE, HDR, BYTES, WRITE, CSUM, DONE.
REQ-017 SHALL, in IDLE, move to HDR on start=1 and clear err; start in any other state is ignored.
REQ-018 SHALL, in HDR, accept one byte as word count N (1..255; 0 means 256), clear word index to 0, initialise checksum to that byte, go to BYTES.
REQ-019 SHALL, in BYTES, accept bytes MSB-first into the word shift register; after the 4th byte go to WRITE.
REQ-020 SHALL, in WRITE (exactly one cycle), drive wr_en=1, wr_addr=word index, wr_data=assembled word, in_ready=0; 4th byte accepted at edge k gives wr_en high in cycle k+1.
REQ-021 SHALL, leaving WRITE, increment the word index and go to BYTES if words remain, else CSUM; index never wraps (256th word writes 0xFF, then CSUM).
REQ-022 SHALL XOR every accepted header and data byte into an 8-bit running checksum.
REQ-023 SHALL, in CSUM, accept one byte; set err=1 if it differs from the running checksum; go to DONE.
REQ-024 SHALL, in DONE (one cycle), drive done=1, then return to IDLE; done pulses regardless of err.
REQ-025 SHALL drive in_ready=1 only in HDR, BYTES, CSUM.
REQ-026 SHALL drive cpu_hold=1 in every state except IDLE.
REQ-027 SHALL hold wr_en=0 outside WRITE; wr_addr/wr_data values outside WRITE are don't-care but stable.
REQ-028 SHALL tolerate arbitrary in_valid gaps in any accepting state without state change.

Reset
REQ-029 SHALL, on reset=1 (any time, including mid-word), immediately force IDLE; in_ready, wr_en, cpu_hold, done, err = 0; wr_addr, wr_data, word index, byte count, checksum = 0.
REQ-030 SHALL discard any partial word on reset; words already written are not rewritten or erased.

Structure
REQ-031 SHALL place the state enum, WORD_BYTES=4 and ADDR_W/DATA_W defaults in shared package cpu_pkg.
REQ-032 SHALL implement byte-to-word assembly (shift register + 2-bit byte counter, word_complete flag) as sub-module word_assembler.

Verification
REQ-033 SHALL cover: start, bytes 02, 38 01 00 05, 38 02 00 01, csum 05 -> wr_en at addr 0 data 0x38010005, addr 1 data 0x38020001, done pulse, err=0, cpu_hold low after DONE.
REQ-034 SHALL cover: same stream with csum 00 -> both writes occur, done pulse, err=1 held until next start.
REQ-035 SHALL cover: header 00, 1024 data bytes -> 256 writes, last wr_addr 0xFF, no wrap, done after csum.
REQ-036 SHALL cover: reset asserted after 2 data bytes of word 0 -> outputs zero asynchronously, no wr_en; fresh load then writes starting at addr 0.
REQ-037 SHALL cover: random in_valid gaps plus start pulses while busy -> identical writes to REQ-033, starts ignored, in_ready=0 during WRITE cycles.
